dma_mem_responder: RTL and testbench

Memory-side responder for the two-channel DMA engine. It owns a single-port word array and services read and write requests from DMA channel 1 and channel 2. Each channel has a one-entry pending buffer. Two-way round-robin arbitration grants one memory access per cycle. Read data is returned with a registered valid pulse, replacing the behavioural memory model used around the DMA today.

---
 rtl/dma_pkg.sv | 13 +
 rtl/rr_arb2.sv | 20 ++
 rtl/dma_mem_responder.sv | 104 ++++++++++
 tb/tb_dma_mem_responder.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// dma_pkg: shared widths, channel indices and pending-entry type for the DMA memory responder
package dma_pkg;
    localparam int DMA_ADDR_W = 8;
    localparam int DMA_DATA_W = 16;
    localparam int CH1 = 0;
    localparam int CH2 = 1;
    typedef struct packed {
        logic                  valid;
        logic                  is_wr;
        logic [DMA_ADDR_W-1:0] addr;
        logic [DMA_DATA_W-1:0] data;
    } pend_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter, ch1 wins the first tie after reset
module rr_arb2
    import dma_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic last_grant;
    // on a tie grant whichever channel was not served last
    always_comb begin
        gnt = (req == 2'b11) ? (last_grant ? 2'b01 : 2'b10) : req;
    end
    // remember the last served channel, only when something is granted
    always_ff @(posedge clk) begin
        if (reset) last_grant <= 1'b1;
        else if (|req) last_grant <= gnt[CH2];
    end
endmodule

// File: rtl/dma_mem_responder.sv
// dma_mem_responder: two-channel memory responder with one-entry pending buffers and round-robin access
module dma_mem_responder
    import dma_pkg::*;
#(
    parameter int DATA_W = DMA_DATA_W,
    parameter int ADDR_W = DMA_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req1,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic              wr_en1,
    input  logic [ADDR_W-1:0] wr_addr1,
    input  logic [DATA_W-1:0] wr_data1,
    output logic              busy1,
    output logic              rd_valid1,
    output logic [DATA_W-1:0] rd_data1,
    output logic              overlap_err1,
    output logic              drop_err1,
    input  logic              rd_req2,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic              wr_en2,
    input  logic [ADDR_W-1:0] wr_addr2,
    input  logic [DATA_W-1:0] wr_data2,
    output logic              busy2,
    output logic              rd_valid2,
    output logic [DATA_W-1:0] rd_data2,
    output logic              overlap_err2,
    output logic              drop_err2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    pend_t             pend [2];
    pend_t             sel;
    logic [1:0]        rd_req, wr_en, gnt, rd_valid, ovl_err, drp_err;
    logic [ADDR_W-1:0] rd_addr [2];
    logic [ADDR_W-1:0] wr_addr [2];
    logic [DATA_W-1:0] wr_data [2];
    logic [DATA_W-1:0] rd_data [2];

    assign rd_req = {rd_req2, rd_req1};
    assign wr_en  = {wr_en2, wr_en1};
    assign rd_addr[CH1] = rd_addr1;
    assign rd_addr[CH2] = rd_addr2;
    assign wr_addr[CH1] = wr_addr1;
    assign wr_addr[CH2] = wr_addr2;
    assign wr_data[CH1] = wr_data1;
    assign wr_data[CH2] = wr_data2;

    assign busy1        = pend[CH1].valid;
    assign busy2        = pend[CH2].valid;
    assign rd_valid1    = rd_valid[CH1];
    assign rd_valid2    = rd_valid[CH2];
    assign rd_data1     = rd_data[CH1];
    assign rd_data2     = rd_data[CH2];
    assign overlap_err1 = ovl_err[CH1];
    assign overlap_err2 = ovl_err[CH2];
    assign drop_err1    = drp_err[CH1];
    assign drop_err2    = drp_err[CH2];
    assign dbg_data     = mem[dbg_addr];

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({pend[CH2].valid, pend[CH1].valid}),
        .gnt   (gnt)
    );

    // the single array access this cycle belongs to the granted channel
    always_comb begin
        sel = gnt[CH2] ? pend[CH2] : pend[CH1];
    end

    // array write port; gated by reset so a pending write dies with the reset
    always_ff @(posedge clk) begin
        if (!reset && (|gnt) && sel.is_wr) mem[sel.addr] <= sel.data;
    end

    // per-channel capture, service, read return and error pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                pend[c].valid <= 1'b0;
                rd_data[c]    <= '0;
            end
            rd_valid <= '0;
            ovl_err  <= '0;
            drp_err  <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                drp_err[c]  <= pend[c].valid & (rd_req[c] | wr_en[c]);
                ovl_err[c]  <= !pend[c].valid & rd_req[c] & wr_en[c];
                rd_valid[c] <= gnt[c] & !pend[c].is_wr;
                if (gnt[c] && !pend[c].is_wr) rd_data[c] <= mem[pend[c].addr];
                if (gnt[c]) pend[c].valid <= 1'b0;
                else if (!pend[c].valid && (rd_req[c] || wr_en[c]))
                    pend[c] <= '{valid: 1'b1, is_wr: wr_en[c],
                                 addr: wr_en[c] ? wr_addr[c] : rd_addr[c],
                                 data: wr_data[c]};
            end
        end
    end
endmodule

// File: tb/tb_dma_mem_responder.sv
// tb_dma_mem_responder: directed scenario checks for the DMA memory responder
module tb_dma_mem_responder;
    logic        clk = 0;
    logic        reset;
    logic        rd_req1, wr_en1, rd_req2, wr_en2;
    logic [7:0]  rd_addr1, wr_addr1, rd_addr2, wr_addr2, dbg_addr;
    logic [15:0] wr_data1, wr_data2;
    logic        busy1, rd_valid1, overlap_err1, drop_err1;
    logic        busy2, rd_valid2, overlap_err2, drop_err2;
    logic [15:0] rd_data1, rd_data2, dbg_data;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dma_mem_responder dut (
        .clk(clk), .reset(reset),
        .rd_req1(rd_req1), .rd_addr1(rd_addr1), .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .busy1(busy1), .rd_valid1(rd_valid1), .rd_data1(rd_data1), .overlap_err1(overlap_err1), .drop_err1(drop_err1),
        .rd_req2(rd_req2), .rd_addr2(rd_addr2), .wr_en2(wr_en2), .wr_addr2(wr_addr2), .wr_data2(wr_data2),
        .busy2(busy2), .rd_valid2(rd_valid2), .rd_data2(rd_data2), .overlap_err2(overlap_err2), .drop_err2(drop_err2),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_req1 = 0; wr_en1 = 0; rd_req2 = 0; wr_en2 = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        rd_addr1 = 0; wr_addr1 = 0; wr_data1 = 0; rd_addr2 = 0; wr_addr2 = 0; wr_data2 = 0; dbg_addr = 0;
        do_reset();
        checks++; if ({busy1, busy2} !== 2'b00) begin errors++; $display("FAIL reset_busy got %b exp 00", {busy1, busy2}); end
        checks++; if ({rd_valid1, rd_valid2} !== 2'b00) begin errors++; $display("FAIL reset_rd_valid got %b exp 00", {rd_valid1, rd_valid2}); end
        checks++; if ({rd_data1, rd_data2} !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", {rd_data1, rd_data2}); end
        checks++; if ({overlap_err1, overlap_err2, drop_err1, drop_err2} !== 4'b0) begin errors++; $display("FAIL reset_errs got %b exp 0000", {overlap_err1, overlap_err2, drop_err1, drop_err2}); end
    endtask

    task automatic test_write();
        wr_en1 = 1; wr_addr1 = 100; wr_data1 = 16'd1010;
        tick();
        idle();
        dbg_addr = 100;
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL wr_busy_c1 got %b exp 1", busy1); end
        tick();
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL wr_busy_c2 got %b exp 0", busy1); end
        checks++; if (dbg_data !== 16'd1010) begin errors++; $display("FAIL wr_dbg got %0d exp 1010", dbg_data); end
        checks++; if (rd_valid1 !== 1'b0) begin errors++; $display("FAIL wr_no_rd_valid got %b exp 0", rd_valid1); end
    endtask

    task automatic test_read();
        rd_req1 = 1; rd_addr1 = 100;
        tick();
        idle();
        checks++; if ({busy1, rd_valid1} !== 2'b10) begin errors++; $display("FAIL rd_c1 busy/valid got %b exp 10", {busy1, rd_valid1}); end
        tick();
        checks++; if ({busy1, rd_valid1} !== 2'b01) begin errors++; $display("FAIL rd_c2 busy/valid got %b exp 01", {busy1, rd_valid1}); end
        checks++; if (rd_data1 !== 16'd1010) begin errors++; $display("FAIL rd_data got %0d exp 1010", rd_data1); end
        tick();
        checks++; if (rd_valid1 !== 1'b0) begin errors++; $display("FAIL rd_pulse_len got %b exp 0", rd_valid1); end
        checks++; if (rd_data1 !== 16'd1010) begin errors++; $display("FAIL rd_data_hold got %0d exp 1010", rd_data1); end
    endtask

    task automatic test_contention();
        do_reset();
        wr_en1 = 1; wr_addr1 = 10; wr_data1 = 16'd1010;
        tick(); idle(); tick();
        wr_en2 = 1; wr_addr2 = 40; wr_data2 = 16'd2040;
        tick(); idle(); tick();
        rd_req1 = 1; rd_addr1 = 10; rd_req2 = 1; rd_addr2 = 40;
        tick();
        idle();
        checks++; if ({busy1, busy2} !== 2'b11) begin errors++; $display("FAIL tie1_busy got %b exp 11", {busy1, busy2}); end
        tick();
        checks++; if ({rd_valid1, rd_valid2} !== 2'b10 || rd_data1 !== 16'd1010) begin errors++; $display("FAIL tie1_first got v=%b d1=%0d exp v=10 d1=1010", {rd_valid1, rd_valid2}, rd_data1); end
        tick();
        checks++; if ({rd_valid1, rd_valid2} !== 2'b01 || rd_data2 !== 16'd2040) begin errors++; $display("FAIL tie1_second got v=%b d2=%0d exp v=01 d2=2040", {rd_valid1, rd_valid2}, rd_data2); end
        rd_req1 = 1; rd_addr1 = 40;
        tick(); idle(); tick();
        checks++; if (rd_data1 !== 16'd2040) begin errors++; $display("FAIL solo_rd got %0d exp 2040", rd_data1); end
        rd_req1 = 1; rd_addr1 = 10; rd_req2 = 1; rd_addr2 = 10;
        tick(); idle(); tick();
        checks++; if ({rd_valid1, rd_valid2} !== 2'b01 || rd_data2 !== 16'd1010) begin errors++; $display("FAIL tie2_first got v=%b d2=%0d exp v=01 d2=1010", {rd_valid1, rd_valid2}, rd_data2); end
        tick();
        checks++; if ({rd_valid1, rd_valid2} !== 2'b10 || rd_data1 !== 16'd1010) begin errors++; $display("FAIL tie2_second got v=%b d1=%0d exp v=10 d1=1010", {rd_valid1, rd_valid2}, rd_data1); end
    endtask

    task automatic test_same_addr();
        do_reset();
        wr_en1 = 1; wr_addr1 = 5; wr_data1 = 16'hAAAA;
        rd_req2 = 1; rd_addr2 = 5;
        tick(); idle(); tick();
        checks++; if (rd_valid2 !== 1'b0) begin errors++; $display("FAIL same_addr_early got %b exp 0", rd_valid2); end
        tick();
        checks++; if (rd_valid2 !== 1'b1 || rd_data2 !== 16'hAAAA) begin errors++; $display("FAIL same_addr_rd got v=%b d=%h exp v=1 d=aaaa", rd_valid2, rd_data2); end
    endtask

    task automatic test_errors();
        rd_req1 = 1; rd_addr1 = 7; wr_en1 = 1; wr_addr1 = 7; wr_data1 = 16'h1234;
        tick();
        idle();
        checks++; if ({overlap_err1, busy1} !== 2'b11) begin errors++; $display("FAIL ovl_pulse got ovl/busy=%b exp 11", {overlap_err1, busy1}); end
        wr_en1 = 1; wr_addr1 = 7; wr_data1 = 16'hFFFF;
        tick();
        idle();
        dbg_addr = 7;
        checks++; if ({drop_err1, overlap_err1, rd_valid1, busy1} !== 4'b1000) begin errors++; $display("FAIL drop_pulse got drop/ovl/rv/busy=%b exp 1000", {drop_err1, overlap_err1, rd_valid1, busy1}); end
        checks++; if (dbg_data !== 16'h1234) begin errors++; $display("FAIL ovl_write got %h exp 1234", dbg_data); end
        tick();
        checks++; if ({drop_err1, rd_valid1, busy1} !== 3'b000 || dbg_data !== 16'h1234) begin errors++; $display("FAIL drop_after got flags=%b d=%h exp 000 1234", {drop_err1, rd_valid1, busy1}, dbg_data); end
    endtask

    task automatic test_reset_mid();
        wr_en2 = 1; wr_addr2 = 9; wr_data2 = 16'h0000;
        tick(); idle(); tick();
        wr_en2 = 1; wr_addr2 = 9; wr_data2 = 16'h5555;
        tick();
        idle();
        reset = 1;
        tick();
        reset = 0;
        dbg_addr = 9;
        checks++; if (dbg_data !== 16'h0000) begin errors++; $display("FAIL rst_mid_mem got %h exp 0000", dbg_data); end
        checks++; if ({busy2, rd_valid2, overlap_err2, drop_err2, overlap_err1, drop_err1} !== 6'b0) begin errors++; $display("FAIL rst_mid_flags got %b exp 000000", {busy2, rd_valid2, overlap_err2, drop_err2, overlap_err1, drop_err1}); end
        tick();
        checks++; if (dbg_data !== 16'h0000 || {busy2, rd_valid2} !== 2'b00) begin errors++; $display("FAIL rst_mid_after got d=%h busy/rv=%b exp 0000 00", dbg_data, {busy2, rd_valid2}); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_contention();
        test_same_addr();
        test_errors();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
